// File: rtl/pixel_upscaler_pkg.sv
// Shared widths, pixel type, colour-bar table and sizing helper for the framebuffer pixel source.
package pixel_upscaler_pkg;

    localparam int DEF_BPC = 2;

    typedef struct packed {
        logic [DEF_BPC-1:0] r;
        logic [DEF_BPC-1:0] g;
        logic [DEF_BPC-1:0] b;
    } rgb_t;

    // Bar index -> {R,G,B} channel enables; reorder here to change the bar sequence.
    localparam logic [7:0][2:0] BAR_TABLE = {
        3'b111, 3'b110, 3'b101, 3'b100, 3'b011, 3'b010, 3'b001, 3'b000
    };

    function automatic int clog2(input longint unsigned n);
        int               r = 0;
        longint unsigned  v = 1;
        while (v < n) begin
            v = v << 1;
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/pixel_upscaler_if.sv
// Frame-load stream: valid/ready words with a start-of-frame marker and a frame-complete flag.
interface pixel_upscaler_if #(
    parameter int BPC = 2
) ();
    logic               load_valid;
    logic               load_sof;
    logic [3*BPC-1:0]   load_data;
    logic               load_ready;
    logic               load_done;

    modport master (
        output load_valid, load_sof, load_data,
        input  load_ready, load_done
    );

    modport slave (
        input  load_valid, load_sof, load_data,
        output load_ready, load_done
    );
endinterface

// File: rtl/pixel_upscaler_fb_ram.sv
// Simple dual-port synchronous frame RAM: one write port, one registered read port, read-first.
module pixel_upscaler_fb_ram #(
    parameter int DEPTH = 120000,
    parameter int AW    = 17,
    parameter int DW    = 6
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data
);

    // NOTE: the array has no reset so it maps onto block RAM; a reset leaves the frame intact.
    logic [DW-1:0] mem [DEPTH];

    // NOTE: non-blocking write and read in one block give read-first on an address collision.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/pixel_upscaler.sv
// Framebuffer pixel source: streamed frame load, integer upscale replay against h/v counters, colour bars.
module pixel_upscaler
    import pixel_upscaler_pkg::*;
#(
    parameter int SRC_W      = 400,
    parameter int SRC_H      = 300,
    parameter int SCALE_LOG2 = 1,
    parameter int BPC        = 2,
    parameter int HCNT_W     = 11,
    parameter int VCNT_W     = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [HCNT_W-1:0] h_count,
    input  logic [VCNT_W-1:0] v_count,
    input  logic              pattern_en,
    pixel_upscaler_if.slave   load,
    output logic [BPC-1:0]    red,
    output logic [BPC-1:0]    green,
    output logic [BPC-1:0]    blue,
    output logic              active
);

    localparam int DEPTH  = SRC_W * SRC_H;
    localparam int AW     = clog2(DEPTH);
    localparam int DW     = 3 * BPC;
    localparam int SX_W   = clog2(SRC_W);
    localparam int SY_W   = clog2(SRC_H);
    localparam int DISP_W = SRC_W << SCALE_LOG2;
    localparam int DISP_H = SRC_H << SCALE_LOG2;

    logic [AW-1:0]   wr_addr;
    logic [AW-1:0]   wr_sel_addr;
    logic            done_q;
    logic            fire;

    logic            in_area;
    logic [SX_W-1:0] sx;
    logic [SY_W-1:0] sy;
    logic [AW-1:0]   rd_addr;
    logic [DW-1:0]   rd_data;

    logic            in_area_q;
    logic            pattern_q;
    logic [SX_W-1:0] sx_q;
    logic [2:0]      bar;
    logic [2:0]      bar_mask;

    // A start-of-frame word is always taken, even once the frame is complete.
    assign load.load_ready = !done_q || load.load_sof;
    assign load.load_done  = done_q;
    assign fire            = load.load_valid && load.load_ready;
    assign wr_sel_addr     = load.load_sof ? '0 : wr_addr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_addr <= '0;
            done_q  <= 1'b0;
        end else if (fire) begin
            if (load.load_sof) begin
                wr_addr <= AW'(1);
                done_q  <= 1'b0;
            end else if (wr_addr == AW'(DEPTH - 1)) begin
                wr_addr <= '0;
                done_q  <= 1'b1;
            end else begin
                wr_addr <= wr_addr + 1'b1;
            end
        end
    end

    pixel_upscaler_fb_ram #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .DW    (DW)
    ) u_fb_ram (
        .clk     (clk),
        .we      (fire),
        .wr_addr (wr_sel_addr),
        .wr_data (load.load_data),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    // S0: map display coordinates back to source pixels; outside the area the RAM reads word 0.
    assign in_area = (32'(h_count) < 32'(DISP_W)) && (32'(v_count) < 32'(DISP_H));
    assign sx      = SX_W'(h_count >> SCALE_LOG2);
    assign sy      = SY_W'(v_count >> SCALE_LOG2);
    assign rd_addr = in_area ? (AW'(sy) * AW'(SRC_W) + AW'(sx)) : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_area_q <= 1'b0;
            pattern_q <= 1'b0;
            sx_q      <= '0;
        end else begin
            in_area_q <= in_area;
            pattern_q <= pattern_en;
            sx_q      <= sx;
        end
    end

    // S1: eight equal-width bars across the source width.
    assign bar      = 3'((32'(sx_q) * 32'd8) / 32'(SRC_W));
    assign bar_mask = BAR_TABLE[bar];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            red    <= '0;
            green  <= '0;
            blue   <= '0;
            active <= 1'b0;
        end else if (!in_area_q) begin
            red    <= '0;
            green  <= '0;
            blue   <= '0;
            active <= 1'b0;
        end else if (pattern_q) begin
            red    <= {BPC{bar_mask[2]}};
            green  <= {BPC{bar_mask[1]}};
            blue   <= {BPC{bar_mask[0]}};
            active <= 1'b1;
        end else begin
            {red, green, blue} <= rd_data;
            active             <= 1'b1;
        end
    end

endmodule

// File: tb/tb_pixel_upscaler.sv
// Self-checking bench for pixel_upscaler on a reduced 40x30 source frame (80x60 displayed).
module tb_pixel_upscaler;
    import pixel_upscaler_pkg::*;

    localparam int SRC_W      = 40;
    localparam int SRC_H      = 30;
    localparam int SCALE_LOG2 = 1;
    localparam int BPC        = 2;
    localparam int HCNT_W     = 11;
    localparam int VCNT_W     = 10;
    localparam int SCALE      = 1 << SCALE_LOG2;
    localparam int DEPTH      = SRC_W * SRC_H;
    localparam int DISP_W     = SRC_W * SCALE;
    localparam int DISP_H     = SRC_H * SCALE;
    localparam int PARK_H     = DISP_W + 20;

    typedef struct packed {
        rgb_t rgb;
        logic act;
    } pix_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic [HCNT_W-1:0] h_count;
    logic [VCNT_W-1:0] v_count;
    logic              pattern_en;
    logic [BPC-1:0]    red, green, blue;
    logic              active;

    pixel_upscaler_if #(.BPC(BPC)) lif ();

    pixel_upscaler #(
        .SRC_W      (SRC_W),
        .SRC_H      (SRC_H),
        .SCALE_LOG2 (SCALE_LOG2),
        .BPC        (BPC),
        .HCNT_W     (HCNT_W),
        .VCNT_W     (VCNT_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .h_count    (h_count),
        .v_count    (v_count),
        .pattern_en (pattern_en),
        .load       (lif),
        .red        (red),
        .green      (green),
        .blue       (blue),
        .active     (active)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    bit cmp_on   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
    endtask

    // Reference model: frame contents as an array, pixels derived straight from the mapping rules.
    logic [5:0] mem_m [DEPTH];
    int         wr_m;
    bit         done_m;
    pix_t       p1, p2;

    function automatic pix_t expect_pix(input int h, input int v, input bit pat);
        pix_t r;
        int   sx, sy, bar;
        r = '0;
        if (h < DISP_W && v < DISP_H) begin
            sx    = h / SCALE;
            sy    = v / SCALE;
            r.act = 1'b1;
            if (pat) begin
                bar     = (sx * 8) / SRC_W;
                r.rgb.r = bar[2] ? 2'b11 : 2'b00;
                r.rgb.g = bar[1] ? 2'b11 : 2'b00;
                r.rgb.b = bar[0] ? 2'b11 : 2'b00;
            end else begin
                r.rgb = mem_m[sy * SRC_W + sx];
            end
        end
        return r;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p1     <= '0;
            p2     <= '0;
            wr_m   <= 0;
            done_m <= 1'b0;
        end else begin
            p2 <= p1;
            p1 <= expect_pix(32'(h_count), 32'(v_count), pattern_en);
            if (lif.load_valid && (!done_m || lif.load_sof)) begin
                if (lif.load_sof) begin
                    mem_m[0] <= lif.load_data;
                    wr_m     <= 1;
                    done_m   <= 1'b0;
                end else begin
                    mem_m[wr_m] <= lif.load_data;
                    if (wr_m == DEPTH - 1) begin
                        wr_m   <= 0;
                        done_m <= 1'b1;
                    end else begin
                        wr_m <= wr_m + 1;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_on) begin
            check("cmp_rgb", 32'({red, green, blue}), 32'(p2.rgb));
            check("cmp_active", 32'(active), 32'(p2.act));
            check("cmp_ready", 32'(lif.load_ready), 32'(!done_m || lif.load_sof));
            check("cmp_done", 32'(lif.load_done), 32'(done_m));
        end
    end

    // Streams words first..first+count-1 (data = index ^ xr) with valid high two cycles in three.
    task automatic stream(input int first, input int count, input logic [5:0] xr);
        int i;
        int cyc;
        bit acc;
        i   = first;
        cyc = 0;
        while (i < first + count && cyc < 4 * count + 10) begin
            lif.load_valid = (cyc % 3) != 2;
            lif.load_sof   = 1'b0;
            lif.load_data  = 6'(i) ^ xr;
            #1;
            acc = lif.load_valid && lif.load_ready;
            if (acc && i == DEPTH - 1) check("done_before_last", 32'(lif.load_done), 0);
            @(posedge clk);
            #1;
            if (acc) begin
                if (i == DEPTH - 1) begin
                    check("done_after_last", 32'(lif.load_done), 1);
                    check("ready_after_last", 32'(lif.load_ready), 0);
                end
                i++;
            end
            cyc++;
        end
        lif.load_valid = 1'b0;
        check("stream_words", i, first + count);
    endtask

    task automatic refuse(input int n);
        lif.load_valid = 1'b1;
        lif.load_sof   = 1'b0;
        lif.load_data  = 6'h15;
        repeat (n) begin
            #1;
            check("refuse_ready", 32'(lif.load_ready), 0);
            @(posedge clk);
            #1;
        end
        lif.load_valid = 1'b0;
    endtask

    task automatic probe(input string name, input int h, input int v, input bit pat,
                         input logic [5:0] rgb_e, input bit act_e);
        h_count    = HCNT_W'(h);
        v_count    = VCNT_W'(v);
        pattern_en = pat;
        repeat (2) @(posedge clk);
        #1;
        check({name, "_rgb"}, 32'({red, green, blue}), 32'(rgb_e));
        check({name, "_act"}, 32'(active), 32'(act_e));
    endtask

    task automatic scan(input int v_lo, input int v_hi, input bit pat);
        pattern_en = pat;
        for (int v = v_lo; v < v_hi; v++) begin
            for (int h = 0; h < PARK_H; h++) begin
                h_count = HCNT_W'(h);
                v_count = VCNT_W'(v);
                @(posedge clk);
                #1;
            end
        end
        h_count = HCNT_W'(PARK_H);
    endtask

    logic [5:0] bar_rgb [8];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        bar_rgb        = '{6'h00, 6'h03, 6'h0C, 6'h0F, 6'h30, 6'h33, 6'h3C, 6'h3F};
        h_count        = HCNT_W'(PARK_H);
        v_count        = '0;
        pattern_en     = 1'b0;
        lif.load_valid = 1'b0;
        lif.load_sof   = 1'b0;
        lif.load_data  = '0;
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("por_done", 32'(lif.load_done), 0);
        check("por_ready", 32'(lif.load_ready), 1);
        check("por_active", 32'(active), 0);
        rst_n  = 1'b1;
        cmp_on = 1'b1;

        // Frame A: data = address[5:0]
        stream(0, DEPTH, 6'h00);
        refuse(3);
        probe("a_h0v0", 0, 0, 0, 6'h00, 1'b1);
        probe("a_h1v1", 1, 1, 0, 6'h00, 1'b1);
        probe("a_h2v1", 2, 1, 0, 6'h01, 1'b1);
        probe("a_h2v3", 2, 3, 0, 6'h29, 1'b1);
        probe("a_h79v0", 79, 0, 0, 6'h27, 1'b1);
        h_count = HCNT_W'(DISP_W);
        @(posedge clk); #1;
        check("edge_h_plus1_act", 32'(active), 1);
        @(posedge clk); #1;
        check("edge_h_plus2_act", 32'(active), 0);
        check("edge_h_plus2_rgb", 32'({red, green, blue}), 0);
        probe("a_last", 79, 59, 0, 6'h2F, 1'b1);
        v_count = VCNT_W'(DISP_H);
        @(posedge clk); #1;
        check("edge_v_plus1_act", 32'(active), 1);
        @(posedge clk); #1;
        check("edge_v_plus2_act", 32'(active), 0);
        probe("a_h80v0", 80, 0, 0, 6'h00, 1'b0);
        scan(0, DISP_H + 4, 1'b0);

        // Colour bars
        probe("bar_h0", 0, 0, 1, 6'h00, 1'b1);
        probe("bar_h70", 70, 0, 1, 6'h3F, 1'b1);
        for (int k = 1; k < 8; k++) begin
            probe("bar_below", 10 * k - 1, 0, 1, bar_rgb[k - 1], 1'b1);
            probe("bar_at", 10 * k, 0, 1, bar_rgb[k], 1'b1);
        end
        probe("bar_out", 80, 5, 1, 6'h00, 1'b0);
        scan(DISP_H - 2, DISP_H + 1, 1'b1);

        // Asynchronous reset while displaying a lit pixel with a complete frame
        probe("pre_rst", 2, 3, 0, 6'h29, 1'b1);
        check("pre_rst_done", 32'(lif.load_done), 1);
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        check("rst_rgb", 32'({red, green, blue}), 0);
        check("rst_active", 32'(active), 0);
        check("rst_done", 32'(lif.load_done), 0);
        check("rst_ready", 32'(lif.load_ready), 1);
        @(posedge clk); #1 rst_n = 1'b1;

        // Partial frame B then reset: unwritten words keep frame A
        h_count = HCNT_W'(PARK_H);
        stream(0, 600, 6'h3F);
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        check("partial_rst_done", 32'(lif.load_done), 0);
        @(posedge clk); #1 rst_n = 1'b1;
        probe("partial_new0", 0, 0, 0, 6'h3F, 1'b1);
        probe("partial_new599", 78, 28, 0, 6'h28, 1'b1);
        probe("partial_old600", 0, 30, 0, 6'h18, 1'b1);
        scan(0, DISP_H, 1'b0);

        // Reload A, then restart with sof while reading address 0 in the same cycle
        stream(0, DEPTH, 6'h00);
        refuse(2);
        probe("reload_0", 0, 0, 0, 6'h00, 1'b1);
        lif.load_valid = 1'b1;
        lif.load_sof   = 1'b1;
        lif.load_data  = 6'h2A;
        #1;
        check("sof_ready_when_done", 32'(lif.load_ready), 1);
        check("sof_done_before", 32'(lif.load_done), 1);
        @(posedge clk); #1;
        lif.load_valid = 1'b0;
        lif.load_sof   = 1'b0;
        check("sof_done_cleared", 32'(lif.load_done), 0);
        @(posedge clk); #1;
        check("sof_same_cycle_old", 32'({red, green, blue}), 32'(6'h00));
        check("sof_same_cycle_act", 32'(active), 1);
        @(posedge clk); #1;
        check("sof_new_word", 32'({red, green, blue}), 32'(6'h2A));
        stream(1, 9, 6'h15);
        probe("sof_word1", 2, 0, 0, 6'h14, 1'b1);

        repeat (3) @(posedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
